pipe_hazard_sched: RTL
======================

// Module: pipe_hazard_sched
// PURPOSE
//  Pipeline hazard scheduler for the 5-stage core. Each cycle it decides whether PC and IF/ID
//  hold, and whether ID/EX takes a bubble (id_lw) or a flush (id_flush).
//  It resolves three cases: load-use hazards, taken branches resolved in EX, and multi-cycle
//  MULT/DIV occupancy (internal FSM + down-counter). It also keeps a saturating stall-cycle counter.
// PARAMETERS
//  MD_CYCLES  32  number of cycles the core stays frozen per MULT/DIV issue (>=2)
//  CNT_W      16  width of stall_cnt
// PORTS
//  clk          in   1      core clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  id_rs        in   5      rs field of instruction in ID
//  id_rt        in   5      rt field of instruction in ID
//  id_use_rs    in   1      ID instruction reads rs
//  id_use_rt    in   1      ID instruction reads rt
//  ex_memread   in   2      MemRead of instruction in EX (!=0 means load)
//  ex_rt        in   5      destination rt of instruction in EX
//  branch_taken in   1      branch/jump in EX resolved taken this cycle
//  md_start     in   1      MULT/DIV in EX this cycle (1-cycle pulse)
//  perf_clr     in   1      synchronous clear of stall_cnt
//  pc_stall     out  1      hold PC
//  if_id_stall  out  1      hold IF/ID register
//  if_flush     out  1      squash IF/ID contents
//  id_flush     out  1      flush ID/EX (bubble)
//  id_lw        out  1      load-use bubble into ID/EX
//  md_busy      out  1      MULT/DIV wait in progress
//  md_done      out  1      1-cycle pulse on last wait cycle
//  stall_cnt    out  CNT_W  cycles with pc_stall=1, saturating
// BEHAVIOUR
//  FSM states: RUN, MDWAIT.
//   RUN->MDWAIT when md_start & !branch_taken; counter loaded with MD_CYCLES-1.
//   MDWAIT: counter decrements every cycle; at 0, md_done=1 and next state is RUN.
//   md_start is ignored while in MDWAIT.
//  luh = (ex_memread!=0) & (ex_rt!=0) & ((id_use_rs & id_rs==ex_rt) | (id_use_rt & id_rt==ex_rt)).
//  Outputs are combinational from state + inputs. Priority is branch > MDWAIT > load-use:
//   branch_taken: if_flush=1, id_flush=1, no stalls, id_lw=0. Applies in any state; does not change state.
//   MDWAIT (no branch): pc_stall=if_id_stall=id_flush=1, md_busy=1; luh is ignored.
//   RUN & luh (no branch): pc_stall=if_id_stall=id_lw=1, exactly 1 bubble.
//    Next cycle the load is in MEM, so luh clears naturally.
//   otherwise all control outputs are 0.
//  The md_start cycle itself does not stall. The freeze starts the next cycle and lasts exactly
//  MD_CYCLES cycles.
//  stall_cnt increments on every cycle with pc_stall=1, saturates at all-ones, and clears on perf_clr.
//   perf_clr wins over increment in the same cycle.
//  Register 0 never creates a hazard (ex_rt==0 check).
//  Reset (async, low): state=RUN, counter=0, stall_cnt=0. All outputs 0 while reset is low.
//   Asserting reset mid-MDWAIT aborts the wait with no md_done pulse.
// TESTING
//  Load r5 in EX, ID reads rs=5 -> one cycle pc_stall=if_id_stall=id_lw=1, then 0; stall_cnt=1.
//  Load r0 in EX, ID reads r0 -> no stall.
//  Load r5 in EX with id_use_rs=0, id_rs=5 -> no stall.
//  md_start pulse, MD_CYCLES=4 -> md_busy/pc_stall/id_flush high for exactly 4 cycles;
//   md_done on the 4th; stall_cnt=4.
//  branch_taken in cycle 2 of MDWAIT -> that cycle if_flush=id_flush=1, pc_stall=0;
//   remaining MDWAIT count unaffected.
//  branch_taken together with luh -> if_flush=id_flush=1, id_lw=0, pc_stall=0.
//  reset low during MDWAIT -> outputs 0 immediately; after release state=RUN and no md_done.
//  stall_cnt at 16'hFFFF with another stall -> stays 16'hFFFF; perf_clr+stall same cycle -> 0.

Source files
------------

// File: rtl/pipe_hazard_sched.sv
// Pipeline hazard scheduler for the 5-stage core.
// Decides PC / IF-ID holds and ID-EX bubble/flush for load-use hazards,
// taken branches resolved in EX and multi-cycle MULT/DIV occupancy, and
// keeps a saturating count of cycles in which the PC was held.
module pipe_hazard_sched #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [1:0]       ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             perf_clr,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             id_lw,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             dbg_state
);

    localparam int MDC_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MDWAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [MDC_W-1:0]   md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               luh;
    logic               md_last;

    // Load-use detection: a load in EX writing a register that ID reads.
    // Register 0 is hardwired, so it can never carry a hazard.
    always_comb begin
        luh = (ex_memread != 2'd0) && (ex_rt != 5'd0) &&
              ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
    end

    // Next-state logic for the MULT/DIV wait FSM and its down-counter.
    // A branch squashes the MULT/DIV in the same cycle, so it blocks entry;
    // once waiting, branches do not disturb the count.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        md_last  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (md_start && !branch_taken) begin
                    state_d  = ST_MDWAIT;
                    md_cnt_d = MDC_W'(MD_CYCLES - 1);
                end
            end
            ST_MDWAIT: begin
                if (md_cnt_q == '0) begin
                    md_last = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    md_cnt_d = md_cnt_q - MDC_W'(1);
                end
            end
            default: begin
                state_d  = ST_RUN;
                md_cnt_d = '0;
            end
        endcase
    end

    // Control outputs: branch > MULT/DIV wait > load-use. Everything is
    // forced low while reset is asserted, including the branch path.
    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        id_lw       = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        if (reset) begin
            if (branch_taken) begin
                if_flush = 1'b1;
                id_flush = 1'b1;
            end else if (state_q == ST_MDWAIT) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_flush    = 1'b1;
            end else if (luh) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_lw       = 1'b1;
            end
            md_busy = (state_q == ST_MDWAIT);
            md_done = md_last;
        end
    end

    // Stall-cycle counter: clear has priority, otherwise saturating increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
        end else if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, wait counter and stall counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign dbg_state = state_q;

endmodule
